// File: rtl/cpu_trace_pkg.sv
// Shared record layout and counter widths for the pipeline event recorder.
// A record is {stamp, kill, push, stall, pc, push_val}, MSB first.
package cpu_trace_pkg;

    localparam int STAMP_W = 16;
    localparam int DROP_W  = 8;
    localparam int PC_W    = 32;
    localparam int PV_W    = 35;
    localparam int TR_W    = 86;

    localparam int PV_LSB     = 0;
    localparam int PV_MSB     = PV_LSB + PV_W - 1;
    localparam int PC_LSB     = PV_MSB + 1;
    localparam int PC_MSB     = PC_LSB + PC_W - 1;
    localparam int FLAG_STALL = PC_MSB + 1;
    localparam int FLAG_PUSH  = FLAG_STALL + 1;
    localparam int FLAG_KILL  = FLAG_PUSH + 1;
    localparam int STAMP_LSB  = FLAG_KILL + 1;
    localparam int STAMP_MSB  = STAMP_LSB + STAMP_W - 1;

    function automatic logic [TR_W-1:0] pack_record(
        input logic [STAMP_W-1:0] stamp,
        input logic               kill,
        input logic               push,
        input logic               stall,
        input logic [PC_W-1:0]    pc,
        input logic [PV_W-1:0]    push_val
    );
        return {stamp, kill, push, stall, pc, push_val};
    endfunction

endpackage

// File: rtl/cpu_trace_if.sv
// Reader-side port bundle of the recorder: record stream, occupancy and drop count.
interface cpu_trace_if #(parameter int DEPTH = 16) ();
    import cpu_trace_pkg::*;

    logic                     tr_valid;
    logic                     tr_ready;
    logic [TR_W-1:0]          tr_data;
    logic [$clog2(DEPTH):0]   tr_count;
    logic [DROP_W-1:0]        tr_drops;
    logic                     drops_clr;

    modport master (
        output tr_valid, tr_data, tr_count, tr_drops,
        input  tr_ready, drops_clr
    );

    modport slave (
        input  tr_valid, tr_data, tr_count, tr_drops,
        output tr_ready, drops_clr
    );

endinterface

// File: rtl/cpu_trace_fifo.sv
// Synchronous FIFO with registered show-ahead head, registered flags and count.
// A push while full is accepted only when a pop frees the head in the same cycle.
module cpu_trace_fifo #(
    parameter int DATA_W = 86,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   push,
    input  logic [DATA_W-1:0]      din,
    output logic                   full,
    input  logic                   pop,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DATA_W-1:0]      dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] head_nxt;

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_nxt   = wr_ptr + {{AW{1'b0}}, push_ok};
        rd_nxt   = rd_ptr + {{AW{1'b0}}, pop_ok};
        cnt_nxt  = wr_nxt - rd_nxt;
        head_nxt = mem[rd_nxt[AW-1:0]];
        // the slot becoming head is being written this cycle: forward it
        if (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
            head_nxt = din;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            empty  <= (cnt_nxt == '0);
            full   <= (cnt_nxt == FULL_CNT);
            if (cnt_nxt != '0)
                dout <= head_nxt;
        end
    end

endmodule

// File: rtl/cpu_trace.sv
// Pipeline event recorder: detects kill/push/stall cycles, stamps and packs a record,
// queues it for a valid/ready reader and counts records lost to a full queue.
module cpu_trace
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter bit CAPTURE_STALL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         trace_en,
    input  logic         kill_4a,
    input  logic [31:0]  pc_4a,
    input  logic         stall_2a,
    input  logic         st__push_5a,
    input  logic [34:0]  st__to_push_5a,
    cpu_trace_if.master  tr
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [STAMP_W-1:0] stamp_cnt;
    logic [DROP_W-1:0]  drop_cnt;
    logic               vld_p0;
    logic [TR_W-1:0]    rec_p0;
    logic               fifo_full, fifo_empty, drop;
    logic [CW-1:0]      fifo_count;
    logic [TR_W-1:0]    fifo_dout;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // ---- p0: event detection and record packing ----
    always_comb begin
        vld_p0 = trace_en && (kill_4a || st__push_5a || (CAPTURE_STALL && stall_2a));
        rec_p0 = pack_record(stamp_cnt, kill_4a, st__push_5a, stall_2a, pc_4a,
                             st__push_5a ? st__to_push_5a : '0);
        drop   = vld_p0 && fifo_full && !(tr.tr_valid && tr.tr_ready);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stamp_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + STAMP_W'(1);
            if (tr.drops_clr)
                drop_cnt <= drop ? DROP_W'(1) : '0;
            else if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // ---- p1: queued records, registered toward the reader ----
    cpu_trace_fifo #(
        .DATA_W (TR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (vld_p0),
        .din   (rec_p0),
        .full  (fifo_full),
        .pop   (tr.tr_ready),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (fifo_dout)
    );

    assign tr.tr_valid = !fifo_empty;
    assign tr.tr_data  = fifo_dout;
    assign tr.tr_count = fifo_count;
    assign tr.tr_drops = drop_cnt;

endmodule

// File: tb/tb_cpu_trace.sv
// Scoreboard bench for cpu_trace: stimulus queues expected records, a monitor
// compares each accepted head; occupancy, drops and stamps are checked directly.
module tb_cpu_trace;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        trace_en, trace_en1;
    logic        kill_4a, stall_2a, st__push_5a;
    logic [31:0] pc_4a;
    logic [34:0] st__to_push_5a;

    always #5 clk = ~clk;

    cpu_trace_if #(.DEPTH(16)) tr0 ();
    cpu_trace_if #(.DEPTH(16)) tr1 ();

    cpu_trace #(.DEPTH(16), .CAPTURE_STALL(1'b0)) dut0 (
        .clk            (clk),
        .rst_b          (rst_b),
        .trace_en       (trace_en),
        .kill_4a        (kill_4a),
        .pc_4a          (pc_4a),
        .stall_2a       (stall_2a),
        .st__push_5a    (st__push_5a),
        .st__to_push_5a (st__to_push_5a),
        .tr             (tr0)
    );

    cpu_trace #(.DEPTH(16), .CAPTURE_STALL(1'b1)) dut1 (
        .clk            (clk),
        .rst_b          (rst_b),
        .trace_en       (trace_en1),
        .kill_4a        (kill_4a),
        .pc_4a          (pc_4a),
        .stall_2a       (stall_2a),
        .st__push_5a    (st__push_5a),
        .st__to_push_5a (st__to_push_5a),
        .tr             (tr1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [85:0] q0[$];
    logic [85:0] q1[$];
    logic [85:0] e0, e1;
    logic [15:0] stamp_m;
    int          mcount;
    int          mdrops;

    // free-running cycle counter the records should be stamped with
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) stamp_m <= 16'd0;
        else        stamp_m <= stamp_m + 16'd1;
    end

    task automatic check_rec(input string name, input logic [85:0] got, input logic [85:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_n(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b && tr0.tr_valid && tr0.tr_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb0_extra: got %h expected no record", tr0.tr_data);
            end else begin
                e0 = q0.pop_front();
                check_rec("sb0_head", tr0.tr_data, e0);
            end
        end
        if (rst_b && tr1.tr_valid && tr1.tr_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1_extra: got %h expected no record", tr1.tr_data);
            end else begin
                e1 = q1.pop_front();
                check_rec("sb1_head", tr1.tr_data, e1);
            end
        end
    end

    // one cycle of stimulus on dut0 plus the queue model for it
    task automatic cyc(input bit en, input bit k, input bit p, input bit s,
                       input logic [31:0] pc, input logic [34:0] v,
                       input bit rdy, input bit clr);
        bit pop, ev, drop;
        trace_en       = en;
        kill_4a        = k;
        st__push_5a    = p;
        stall_2a       = s;
        pc_4a          = pc;
        st__to_push_5a = v;
        tr0.tr_ready   = rdy;
        tr0.drops_clr  = clr;
        pop  = rdy && (mcount > 0);
        ev   = en && (k || p);
        drop = ev && (mcount == 16) && !pop;
        if (ev && !drop) begin
            q0.push_back({stamp_m, k, p, s, pc, (p ? v : 35'd0)});
            mcount++;
        end
        if (pop) mcount--;
        if (clr)                        mdrops = drop ? 1 : 0;
        else if (drop && mdrops < 255)  mdrops++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 35'd0, rdy, 1'b0);
    endtask

    initial begin
        rst_b = 1'b1;
        trace_en = 1'b0; trace_en1 = 1'b0;
        kill_4a = 1'b0; stall_2a = 1'b0; st__push_5a = 1'b0;
        pc_4a = 32'd0; st__to_push_5a = 35'd0;
        tr0.tr_ready = 1'b0; tr0.drops_clr = 1'b0;
        tr1.tr_ready = 1'b0; tr1.drops_clr = 1'b0;
        mcount = 0; mdrops = 0;

        #1 rst_b = 1'b0;
        #2;
        check_n("rst_valid", int'(tr0.tr_valid), 0);
        check_n("rst_count", int'(tr0.tr_count), 0);
        check_n("rst_drops", int'(tr0.tr_drops), 0);
        check_rec("rst_data", tr0.tr_data, 86'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;

        // single push in cycle 5
        idle(1'b0, 5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 35'h4_0000_0ABC, 1'b0, 1'b0);
        check_n("single_valid", int'(tr0.tr_valid), 1);
        check_n("single_count", int'(tr0.tr_count), 1);
        check_rec("single_data", tr0.tr_data,
                  {16'd5, 1'b0, 1'b1, 1'b0, 32'h100, 35'h4_0000_0ABC});
        idle(1'b1, 2);
        check_n("single_drained", int'(tr0.tr_count), 0);

        // stall-only cycles: ignored by dut0, recorded by dut1
        trace_en1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q1.push_back({stamp_m, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 35'd0});
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 35'd0, 1'b0, 1'b0);
        end
        trace_en1 = 1'b0;
        check_n("stall_off_count", int'(tr0.tr_count), 0);
        check_n("stall_on_count", int'(tr1.tr_count), 10);
        tr1.tr_ready = 1'b1;
        idle(1'b0, 11);
        tr1.tr_ready = 1'b0;
        check_n("stall_on_drained", int'(tr1.tr_count), 0);

        // overflow: 20 kills into a 16-deep queue with no reader
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(i), 35'd0, 1'b0, 1'b0);
        check_n("ovf_count", int'(tr0.tr_count), 16);
        check_n("ovf_drops", int'(tr0.tr_drops), 4);

        // full with simultaneous pop: no loss, occupancy holds
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(i), 35'd0, 1'b1, 1'b0);
        check_n("fullpop_count", int'(tr0.tr_count), 16);
        check_n("fullpop_drops", int'(tr0.tr_drops), 4);
        idle(1'b1, 17);
        check_n("fullpop_drained", int'(tr0.tr_count), 0);

        // saturation, then clear together with a drop
        for (int i = 0; i < 316; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i), 35'd0, 1'b0, 1'b0);
        check_n("sat_drops", int'(tr0.tr_drops), 255);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 35'd0, 1'b0, 1'b1);
        check_n("clr_drop_drops", int'(tr0.tr_drops), 1);
        check_n("clr_model_drops", int'(tr0.tr_drops), mdrops);
        idle(1'b1, 17);
        check_n("sat_drained", int'(tr0.tr_count), 0);

        // asynchronous reset with records stored
        for (int i = 0; i < 7; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h400 + 32'(i), 35'h1_0000_0000 + 35'(i), 1'b0, 1'b0);
        check_n("prerst_count", int'(tr0.tr_count), 7);
        #2 rst_b = 1'b0;
        #1;
        check_n("arst_valid", int'(tr0.tr_valid), 0);
        check_n("arst_count", int'(tr0.tr_count), 0);
        check_n("arst_drops", int'(tr0.tr_drops), 0);
        check_rec("arst_data", tr0.tr_data, 86'd0);
        q0.delete(); mcount = 0; mdrops = 0;
        @(negedge clk) rst_b = 1'b1;
        idle(1'b0, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 35'd0, 1'b0, 1'b0);
        check_n("postrst_valid", int'(tr0.tr_valid), 1);
        check_n("postrst_stamp", int'(tr0.tr_data[85:70]), 3);
        idle(1'b1, 2);

        // stamp wrap: events 65536 cycles apart share stamp 0
        #2 rst_b = 1'b0;
        q0.delete(); mcount = 0; mdrops = 0;
        @(negedge clk) rst_b = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 35'd0, 1'b0, 1'b0);
        check_n("wrap_first_stamp", int'(tr0.tr_data[85:70]), 0);
        idle(1'b1, 1);
        idle(1'b0, 65534);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h601, 35'd0, 1'b0, 1'b0);
        check_n("wrap_valid", int'(tr0.tr_valid), 1);
        check_n("wrap_second_stamp", int'(tr0.tr_data[85:70]), 0);
        idle(1'b1, 2);

        check_n("sb0_leftover", q0.size(), 0);
        check_n("sb1_leftover", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
